// File: rtl/serial_sub_ctrl_if.sv
// Handshake/bus bundle for the bit-serial subtractor controller.
// Latency/backpressure: none of its own; plain wires between requester and controller.
// Ports: start/a/b flow requester -> controller; busy/done/diff/borrow_out/zero flow back.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, zero
  );

  // Controller side.
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, zero
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b using one full-subtractor cell, LSB first, one bit per clock.
// Latency: WIDTH+1 edges from accepted start to the done pulse; one result per WIDTH+1 cycles.
// Backpressure: start is only accepted in IDLE or DONE; a start seen during RUN is dropped.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries start/a/b in and
// busy/done/diff/borrow_out/zero out. Results hold until the next completion or reset.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_sub_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             bq_q, bq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  // Full-subtractor cell on the current LSBs and recirculated borrow.
  logic             x, y, c;
  logic             d_bit, bo_bit;
  logic [WIDTH-1:0] r_next;

  assign x      = a_sh_q[0];
  assign y      = b_sh_q[0];
  assign c      = bq_q;
  assign d_bit  = x ^ y ^ c;
  assign bo_bit = (~x & y) | (~x & c) | (y & c);

  // Result enters at the MSB and moves right; shift form also covers WIDTH == 1.
  assign r_next = (r_sh_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      bq_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      bq_q     <= bq_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    bq_d     = bq_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;

    case (state_q)
      // DONE behaves like IDLE for acceptance so back-to-back starts lose no cycle.
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          bq_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = r_next;
        bq_d   = bo_bit;
        cnt_d  = cnt_q + CW'(1);
        // Final bit: publish the completed word including this bit's difference.
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          diff_d   = r_next;
          borrow_d = bo_bit;
          zero_d   = (r_next == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.zero       = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(W)) bus8 ();
  serial_sub_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_sub_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int vectors = 0;
  int errors  = 0;

  // Last published result of each DUT, as predicted by the model.
  logic [7:0] last_diff;
  logic       last_bo, last_zero;
  logic       last1_diff, last1_bo, last1_zero;

  // {busy, done, diff, borrow_out, zero}
  function automatic logic [11:0] obs8();
    return {bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.zero};
  endfunction

  function automatic logic [4:0] obs1();
    return {bus1.busy, bus1.done, bus1.diff, bus1.borrow_out, bus1.zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    bus1.start = 1'b0; bus1.a = 1'b1; bus1.b = 1'b0;
    tick();
    tick();
    for (int t = 0; t < 3; t++) begin
      vectors++;
      if (obs8() !== 12'h000) begin
        errors++;
        $display("FAIL reset8 t=%0d: got %03h expected 000", t, obs8());
      end
      vectors++;
      if (obs1() !== 5'h00) begin
        errors++;
        $display("FAIL reset1 t=%0d: got %02h expected 00", t, obs1());
      end
      rst = 1'b0;
      tick();
    end
    last_diff = 8'd0; last_bo = 1'b0; last_zero = 1'b0;
    last1_diff = 1'b0; last1_bo = 1'b0; last1_zero = 1'b0;
  endtask

  // Directed boundaries first, then random operands.
  task automatic test_basic();
    logic [7:0] ta [3] = '{8'd100, 8'd0, 8'd255};
    logic [7:0] tb_ [3] = '{8'd37, 8'd1, 8'd255};
    for (int n = 0; n < 12; n++) begin
      logic [7:0]  a, b, ed;
      logic        ebo, ez;
      logic [11:0] exp;
      a = (n < 3) ? ta[n] : 8'($urandom_range(0, 255));
      b = (n < 3) ? tb_[n] : 8'($urandom_range(0, 255));
      ed  = 8'((int'(a) - int'(b) + 256) % 256);
      ebo = (a < b);
      ez  = (ed == 8'd0);
      bus8.start = 1'b1; bus8.a = a; bus8.b = b;
      tick();
      bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      for (int t = 0; t <= W + 1; t++) begin
        if (t < W) exp = {1'b1, 1'b0, last_diff, last_bo, last_zero};
        else       exp = {1'b0, (t == W), ed, ebo, ez};
        vectors++;
        if (obs8() !== exp) begin
          errors++;
          $display("FAIL basic a=%0d b=%0d t=%0d: got %03h expected %03h", a, b, t, obs8(), exp);
        end
        tick();
      end
      last_diff = ed; last_bo = ebo; last_zero = ez;
    end
  endtask

  task automatic test_ignore_start();
    logic [11:0] exp;
    bus8.start = 1'b1; bus8.a = 8'd10; bus8.b = 8'd3;
    tick();
    bus8.start = 1'b0;
    for (int t = 0; t <= W + 1; t++) begin
      if (t < W) exp = {1'b1, 1'b0, last_diff, last_bo, last_zero};
      else       exp = {1'b0, (t == W), 8'd7, 1'b0, 1'b0};
      vectors++;
      if (obs8() !== exp) begin
        errors++;
        $display("FAIL ignore t=%0d: got %03h expected %03h", t, obs8(), exp);
      end
      bus8.start = (t == 2);
      bus8.a = 8'd200; bus8.b = 8'd1;
      tick();
    end
    bus8.start = 1'b0;
    last_diff = 8'd7; last_bo = 1'b0; last_zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    int          ph;
    bus8.start = 1'b1; bus8.a = 8'd50; bus8.b = 8'd60;
    tick();
    for (int t = 0; t <= 3 * (W + 1); t++) begin
      ph = t % (W + 1);
      if (t == 3 * (W + 1))  exp = {1'b0, 1'b0, 8'd246, 1'b1, 1'b0};
      else if (t < W)        exp = {1'b1, 1'b0, last_diff, last_bo, last_zero};
      else                   exp = {(ph != W), (ph == W), 8'd246, 1'b1, 1'b0};
      vectors++;
      if (obs8() !== exp) begin
        errors++;
        $display("FAIL b2b t=%0d: got %03h expected %03h", t, obs8(), exp);
      end
      if (t == 3 * (W + 1) - 1) bus8.start = 1'b0;
      tick();
    end
    last_diff = 8'd246; last_bo = 1'b1; last_zero = 1'b0;
  endtask

  task automatic test_abort();
    logic [11:0] exp;
    bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd4;
    tick();
    bus8.start = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_diff = 8'd0; last_bo = 1'b0; last_zero = 1'b0;
    last1_diff = 1'b0; last1_bo = 1'b0; last1_zero = 1'b0;
    for (int t = 0; t <= W + 1; t++) begin
      vectors++;
      if (obs8() !== 12'h000) begin
        errors++;
        $display("FAIL abort_idle t=%0d: got %03h expected 000", t, obs8());
      end
      tick();
    end
    bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd4;
    tick();
    bus8.start = 1'b0;
    for (int t = 0; t <= W + 1; t++) begin
      if (t < W) exp = {1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
      else       exp = {1'b0, (t == W), 8'd5, 1'b0, 1'b0};
      vectors++;
      if (obs8() !== exp) begin
        errors++;
        $display("FAIL abort_restart t=%0d: got %03h expected %03h", t, obs8(), exp);
      end
      tick();
    end
    last_diff = 8'd5;
  endtask

  task automatic test_width1();
    logic [4:0] exp;
    logic       ed, ebo, ez;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        ed  = 1'((a - b + 2) % 2);
        ebo = (a < b);
        ez  = (ed == 1'b0);
        bus1.start = 1'b1; bus1.a = 1'(a); bus1.b = 1'(b);
        tick();
        bus1.start = 1'b0; bus1.a = 1'($urandom); bus1.b = 1'($urandom);
        for (int t = 0; t <= 2; t++) begin
          if (t == 0) exp = {1'b1, 1'b0, last1_diff, last1_bo, last1_zero};
          else        exp = {1'b0, (t == 1), ed, ebo, ez};
          vectors++;
          if (obs1() !== exp) begin
            errors++;
            $display("FAIL w1 a=%0d b=%0d t=%0d: got %02h expected %02h", a, b, t, obs1(), exp);
          end
          tick();
        end
        last1_diff = ed; last1_bo = ebo; last1_zero = ez;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
